mld_15_7_stream_encoder: RTL

//  Upstream stage of the (15,7) Type II majority-logic decoder: accepts a 7-bit message on a

---
 rtl/mld_15_7_pkg.sv | 8 +
 rtl/mld_15_7_lfsr_enc.sv | 28 ++
 rtl/mld_15_7_stream_encoder.sv | 118 +++++++++++
 3 files changed

// File: rtl/mld_15_7_pkg.sv
// mld_15_7_pkg: shared code constants and FSM encoding for the (15,7) stream encoder
package mld_15_7_pkg;
    localparam int N = 15;
    localparam int K = 7;
    localparam int P = 8;
    localparam logic [7:0] G_POLY_DEFAULT = 8'hD1;
    typedef enum logic [1:0] {IDLE = 2'd0, MSG = 2'd1, PAR = 2'd2, DECODE = 2'd3} state_e;
endpackage

// File: rtl/mld_15_7_lfsr_enc.sv
// mld_15_7_lfsr_enc: serial divide-by-g(x) register that accumulates the 8 parity bits
module mld_15_7_lfsr_enc
#(
    parameter logic [7:0] G_POLY = 8'hD1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       fb_en,
    input  logic       in_bit,
    output logic [7:0] r_next
);
    logic [7:0] r;
    logic       fb;
    // next remainder: shift up, folding the feedback into the generator taps while dividing
    always_comb begin
        fb = fb_en & (in_bit ^ r[7]);
        r_next = {r[6:0], 1'b0} ^ (G_POLY & {8{fb}});
    end
    // clear has priority so every frame divides from a zero remainder
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r <= '0;
        else if (clr) r <= '0;
        else if (en) r <= r_next;
    end
endmodule

// File: rtl/mld_15_7_stream_encoder.sv
// mld_15_7_stream_encoder: feeds one systematic (15,7) codeword per message to the decoder; MLD_ERR_INJECT_EN adds err_mask
module mld_15_7_stream_encoder
    import mld_15_7_pkg::*;
#(
    parameter logic [7:0] G_POLY        = G_POLY_DEFAULT,
    parameter int         DECODE_CYCLES = 15
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        msg_valid,
    input  logic [6:0]  msg_data,
`ifdef MLD_ERR_INJECT_EN
    input  logic [14:0] err_mask,
`endif
    output logic        msg_ready,
    output logic        tx_bit,
    output logic        tx_load,
    output logic        frame_done,
    output logic        busy
);
    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_MSG    = MSG;
    localparam logic [1:0] S_PAR    = PAR;
    localparam logic [1:0] S_DECODE = DECODE;

    logic [1:0] state, nxt_state;
    logic [4:0] cnt, nxt_cnt;
    logic [6:0] msg_q, msg_src;
    logic [7:0] r_next;
    logic [2:0] msg_idx, lfsr_idx;
    logic       accept, tx_on, clean_bit, err_bit;

    assign msg_ready = (state == S_IDLE) && !reset;
    assign accept    = msg_valid && msg_ready;
    assign msg_src   = accept ? msg_data : msg_q;
    assign lfsr_idx  = 3'(K - 1) - cnt[2:0];

    mld_15_7_lfsr_enc #(.G_POLY(G_POLY)) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .clr    (accept),
        .en     (state == S_MSG || state == S_PAR),
        .fb_en  (state == S_MSG),
        .in_bit (msg_q[lfsr_idx]),
        .r_next (r_next)
    );

    // frame sequencing: IDLE -> MSG (K) -> PAR (P) -> DECODE (DECODE_CYCLES) -> IDLE
    always_comb begin
        nxt_state = state;
        nxt_cnt = cnt + 5'd1;
        case (state)
            S_IDLE: begin
                nxt_cnt = '0;
                if (accept) nxt_state = S_MSG;
            end
            S_MSG: if (cnt == 5'(K - 1)) begin
                nxt_state = S_PAR;
                nxt_cnt = '0;
            end
            S_PAR: if (cnt == 5'(P - 1)) begin
                nxt_state = S_DECODE;
                nxt_cnt = '0;
            end
            default: if (cnt == 5'(DECODE_CYCLES - 1)) begin
                nxt_state = S_IDLE;
                nxt_cnt = '0;
            end
        endcase
    end

    // outputs are registered, so the bit for the coming cycle is chosen from the next state
    always_comb begin
        tx_on = (nxt_state == S_MSG) || (nxt_state == S_PAR);
        msg_idx = 3'(K - 1) - nxt_cnt[2:0];
        clean_bit = (nxt_state == S_MSG) ? msg_src[msg_idx] : r_next[7];
    end

`ifdef MLD_ERR_INJECT_EN
    logic [14:0] em_q, em_src;
    logic [3:0]  cw_idx;
    assign em_src = accept ? err_mask : em_q;
    // codeword position of the bit going out next, used to pick its error flip
    always_comb begin
        cw_idx = (nxt_state == S_MSG) ? 4'(N - 1) - nxt_cnt[3:0] : 4'(P - 1) - nxt_cnt[3:0];
        err_bit = em_src[cw_idx];
    end
    // error mask is captured together with the message
    always_ff @(posedge clk or posedge reset) begin
        if (reset) em_q <= '0;
        else em_q <= em_src;
    end
`else
    assign err_bit = 1'b0;
`endif

    // state, counter, message and glitch-free output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            msg_q      <= '0;
            tx_bit     <= 1'b0;
            tx_load    <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            msg_q      <= msg_src;
            tx_bit     <= tx_on & (clean_bit ^ err_bit);
            tx_load    <= tx_on;
            frame_done <= (nxt_state == S_DECODE) && (nxt_cnt == 5'(DECODE_CYCLES - 1));
            busy       <= nxt_state != S_IDLE;
        end
    end
endmodule
